// File: rtl/predictor_pkg.sv
// Shared types for the 2-bit branch predictor and its resolver.
// Counter encodings, resolver FSM states, default queue depth.
package predictor_pkg;

   typedef enum logic [1:0] {
      SNT = 2'd0,
      WNT = 2'd1,
      WT  = 2'd2,
      ST  = 2'd3
   } cnt_e;

   typedef enum logic {
      RUN   = 1'b0,
      FLUSH = 1'b1
   } res_state_e;

   localparam int DEF_DEPTH = 4;

   // Saturating 2-bit counter step used by the predictor side.
   function automatic cnt_e cnt_step(cnt_e c, logic taken);
      cnt_e n;
      n = c;
      if (taken && c != ST)
         n = cnt_e'(c + 2'd1);
      else if (!taken && c != SNT)
         n = cnt_e'(c - 2'd1);
      return n;
   endfunction

endpackage

// File: rtl/branch_resolver_if.sv
// Fetch / execute / predictor handshake bundle of the resolver.
// slave = resolver view, master = environment view.
interface branch_resolver_if;

   logic br_valid;
   logic br_ready;
   logic br_pred_valid;
   logic br_pred;
   logic pred_request;
   logic pred_prediction;
   logic pred_result;
   logic pred_taken;
   logic res_valid;
   logic res_taken;
   logic res_ready;
   logic mispredict;

   modport slave (
      input  br_valid, pred_prediction,
      input  res_valid, res_taken,
      output br_ready, br_pred_valid, br_pred,
      output pred_request, pred_result, pred_taken,
      output res_ready, mispredict
   );

   modport master (
      output br_valid, pred_prediction,
      output res_valid, res_taken,
      input  br_ready, br_pred_valid, br_pred,
      input  pred_request, pred_result, pred_taken,
      input  res_ready, mispredict
   );

endinterface

// File: rtl/br_fifo.sv
// 1-bit-wide DEPTH-entry in-order queue of predictions.
// Pointers wrap modulo DEPTH; clear beats push and pop.
module br_fifo #(
   parameter  int DEPTH = 4,
   localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_push,
   input  logic          i_din,
   input  logic          i_pop,
   input  logic          i_clear,
   output logic          o_head,
   output logic [CW-1:0] o_count
);

   logic [DEPTH-1:0] r_mem;
   logic [PW-1:0]    r_wr;
   logic [PW-1:0]    r_rd;
   logic [CW-1:0]    r_cnt;

   function automatic logic [PW-1:0] nxt(logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // Storage write at the tail; contents need no reset.
   always_ff @(posedge clk) begin
      if (i_push && !i_clear)
         r_mem[r_wr] <= i_din;
   end

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr  <= '0;
         r_rd  <= '0;
         r_cnt <= '0;
      end else if (i_clear) begin
         r_wr  <= '0;
         r_rd  <= '0;
         r_cnt <= '0;
      end else begin
         if (i_push)
            r_wr <= nxt(r_wr);
         if (i_pop)
            r_rd <= nxt(r_rd);
         if (i_push && !i_pop)
            r_cnt <= r_cnt + CW'(1);
         else if (!i_push && i_pop)
            r_cnt <= r_cnt - CW'(1);
      end
   end

   assign o_head  = r_mem[r_rd];
   assign o_count = r_cnt;

endmodule

// File: rtl/branch_resolver.sv
// Requesting/updating end of the 2-bit branch predictor.
// PERF_CNT_EN adds saturating br_count / mis_count outputs.
module branch_resolver
   import predictor_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH
`ifdef PERF_CNT_EN
   ,
   parameter int CNT_W = 16
`endif
) (
   input  logic             clk,
   input  logic             rst,
   branch_resolver_if.slave bus
`ifdef PERF_CNT_EN
   ,
   output logic [CNT_W-1:0] br_count,
   output logic [CNT_W-1:0] mis_count
`endif
);

   localparam int CW = $clog2(DEPTH + 1);

   res_state_e    r_state;
   res_state_e    w_state_nxt;
   logic          r_pending;
   logic          r_result;
   logic          r_taken;
   logic          r_mis;
   logic          w_head;
   logic [CW-1:0] w_occ;
   logic [CW:0]   w_fill;
   logic          w_run;
   logic          w_res_acc;
   logic          w_mis;
   logic          w_acc;

   assign w_run     = (r_state == RUN);
   assign w_fill    = {1'b0, w_occ} + {{CW{1'b0}}, r_pending};
   assign w_res_acc = bus.res_ready && bus.res_valid;
   assign w_mis     = w_res_acc && (w_head != bus.res_taken);
   assign w_acc     = bus.br_valid && bus.br_ready && !rst;

   assign bus.res_ready     = w_run && (w_occ != '0);
   assign bus.br_ready      = w_run && !w_mis &&
                              (w_fill < (CW+1)'(DEPTH));
   assign bus.pred_request  = w_acc;
   assign bus.br_pred_valid = r_pending;
   assign bus.br_pred       = r_pending & bus.pred_prediction;
   assign bus.pred_result   = r_result;
   assign bus.pred_taken    = r_taken;
   assign bus.mispredict    = r_mis;

   br_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (r_pending && !w_mis),
      .i_din   (bus.pred_prediction),
      .i_pop   (w_res_acc),
      .i_clear (w_mis),
      .o_head  (w_head),
      .o_count (w_occ)
   );

   // Resolver state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_state <= RUN;
      else
         r_state <= w_state_nxt;
   end

   // Next state: a mispredict costs exactly one flush cycle.
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         RUN:   if (w_mis) w_state_nxt = FLUSH;
         FLUSH: w_state_nxt = RUN;
      endcase
   end

   // Capture-pending flag and one-cycle predictor update pulses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pending <= 1'b0;
         r_result  <= 1'b0;
         r_taken   <= 1'b0;
         r_mis     <= 1'b0;
      end else begin
         r_pending <= w_acc && !w_mis;
         r_result  <= w_res_acc;
         r_taken   <= w_res_acc && bus.res_taken;
         r_mis     <= w_mis;
      end
   end

`ifdef PERF_CNT_EN
   // Saturating event counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         br_count  <= '0;
         mis_count <= '0;
      end else begin
         if (w_acc && br_count != '1)
            br_count <= br_count + CNT_W'(1);
         if (w_mis && mis_count != '1)
            mis_count <= mis_count + CNT_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Scoreboard bench for branch_resolver (DEPTH=4).
// Handshakes checked against a cycle model; update pulses via queue.
module tb_branch_resolver;

   localparam int DEPTH = 4;

   typedef struct packed {
      bit taken;
      bit mis;
   } res_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   branch_resolver_if bus ();

`ifdef PERF_CNT_EN
   logic [15:0] br_count;
   logic [15:0] mis_count;
`endif

   branch_resolver #(.DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
`ifdef PERF_CNT_EN
      ,
      .br_count  (br_count),
      .mis_count (mis_count)
`endif
   );

   int   errs   = 0;
   int   checks = 0;
   bit   m_q[$];
   bit   m_pend  = 0;
   bit   m_pval  = 0;
   bit   m_flush = 0;
   res_t exp_res[$];
   int   m_brs   = 0;
   int   m_mis   = 0;
   int   n_pulse = 0;
   int   base;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   // Predictor-update pulses popped against the scoreboard.
   always @(negedge clk) begin : mon
      res_t e;
      if (!rst) begin
         if (bus.pred_result === 1'b1) begin
            n_pulse++;
            chk("res_q_nonempty", 32'(exp_res.size() != 0), 1);
            if (exp_res.size() != 0) begin
               e = exp_res.pop_front();
               chk("pred_taken", bus.pred_taken, e.taken);
               chk("mispredict", bus.mispredict, e.mis);
            end
         end else begin
            chk("mis_idle", bus.mispredict, 0);
         end
      end
   end

   // One clock: drive, check combinational handshakes, advance model.
   task automatic cyc(input bit bv, input bit rv, input bit rt,
                      input bit p);
      bit e_rr, e_ra, e_mis, e_br, e_acc;
      bus.br_valid        = bv;
      bus.res_valid       = rv;
      bus.res_taken       = rt;
      bus.pred_prediction = m_pend ? m_pval : 1'($urandom % 2);
      e_rr  = !m_flush && m_q.size() > 0;
      e_ra  = e_rr && rv;
      e_mis = e_ra && (m_q[0] != rt);
      e_br  = !m_flush && !e_mis && (m_q.size() + m_pend < DEPTH);
      e_acc = bv && e_br;
      @(negedge clk);
      chk("res_ready", bus.res_ready, e_rr);
      chk("br_ready", bus.br_ready, e_br);
      chk("pred_request", bus.pred_request, e_acc);
      chk("br_pred_valid", bus.br_pred_valid, m_pend);
      if (m_pend)
         chk("br_pred", bus.br_pred, m_pval);
      if (e_ra)
         exp_res.push_back('{taken: rt, mis: e_mis});
      if (e_acc) m_brs++;
      if (e_mis) m_mis++;
      if (e_mis) begin
         m_q.delete();
         m_pend  = 0;
         m_flush = 1;
      end else begin
         m_flush = 0;
         if (e_ra)
            void'(m_q.pop_front());
         if (m_pend)
            m_q.push_back(m_pval);
         m_pend = e_acc;
         if (e_acc)
            m_pval = p;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset();
      chk("rst_br_ready", bus.br_ready, 1);
      chk("rst_res_ready", bus.res_ready, 0);
      chk("rst_br_pred_valid", bus.br_pred_valid, 0);
      chk("rst_br_pred", bus.br_pred, 0);
      chk("rst_pred_request", bus.pred_request, 0);
      chk("rst_pred_result", bus.pred_result, 0);
      chk("rst_pred_taken", bus.pred_taken, 0);
      chk("rst_mispredict", bus.mispredict, 0);
`ifdef PERF_CNT_EN
      chk("rst_br_count", 32'(br_count), 0);
      chk("rst_mis_count", 32'(mis_count), 0);
`endif
   endtask

   task automatic drain();
      for (int i = 0; i < 20; i++)
         if (m_q.size() > 0 || m_pend)
            cyc(0, 1, (m_q.size() > 0) ? m_q[0] : 1'b0, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      bus.br_valid        = 0;
      bus.res_valid       = 0;
      bus.res_taken       = 0;
      bus.pred_prediction = 0;
      #12;
      chk_reset();
      @(posedge clk);
      #1;
      rst = 0;

      // single branch, predictor says taken
      cyc(1, 0, 0, 1);
      cyc(0, 0, 0, 0);
      cyc(0, 1, 1, 0);
      cyc(0, 0, 0, 0);

      // fill to DEPTH, fifth branch stalls
      repeat (6) cyc(1, 0, 0, 1);
      chk("full_stall", bus.br_ready, 0);
      cyc(0, 0, 0, 0);

      // resolve four correct
      base = n_pulse;
      repeat (4) cyc(0, 1, 1, 0);
      cyc(0, 0, 0, 0);
      cyc(0, 0, 0, 0);
      chk("four_pulses", 32'(n_pulse - base), 4);

      // mispredict on oldest of three
      cyc(1, 0, 0, 1);
      cyc(1, 0, 0, 0);
      cyc(1, 0, 0, 1);
      cyc(0, 0, 0, 0);
      cyc(0, 1, 0, 0);
      cyc(1, 0, 0, 0);
      cyc(0, 1, 0, 0);
      cyc(0, 0, 0, 0);

      // accept + correct resolve at occupancy 2
      cyc(1, 0, 0, 1);
      cyc(1, 0, 0, 0);
      cyc(0, 0, 0, 0);
      cyc(1, 1, 1, 1);
      cyc(0, 0, 0, 0);
      cyc(0, 1, 0, 0);
      cyc(0, 1, 1, 0);
      cyc(0, 0, 0, 0);

      // random traffic
      repeat (300)
         cyc(1'($urandom % 2), 1'($urandom % 2),
             1'($urandom % 2), 1'($urandom % 2));
      cyc(0, 0, 0, 0);
`ifdef PERF_CNT_EN
      chk("br_count", 32'(br_count), 32'(m_brs));
      chk("mis_count", 32'(mis_count), 32'(m_mis));
`endif

      // reset with three in flight and a pulse in progress
      drain();
      cyc(0, 0, 0, 0);
      cyc(1, 0, 0, 1);
      cyc(1, 0, 0, 0);
      cyc(1, 0, 0, 1);
      cyc(0, 0, 0, 0);
      cyc(1, 1, 1, 0);
      rst           = 1;
      bus.br_valid  = 0;
      bus.res_valid = 0;
      #1;
      chk_reset();
      m_q.delete();
      m_pend  = 0;
      m_flush = 0;
      exp_res.delete();
      @(posedge clk);
      #1;
      rst = 0;
      cyc(0, 1, 0, 0);
      cyc(1, 0, 0, 0);
      cyc(0, 0, 0, 0);
      cyc(0, 1, 0, 0);
      cyc(0, 0, 0, 0);
      cyc(0, 0, 0, 0);

      chk("res_q_empty", 32'(exp_res.size()), 0);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
